// File: rtl/alu_pkg.sv
// Shared types for the registered sequential ALU: op encoding, FSM states, widths.
package alu_pkg;

  localparam int OP_W = 3;
  localparam int ST_W = 1;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, N cycles,
// then a one-cycle done pulse with the full 2N-bit product held in prod.
module seq_alu_mul
  import alu_pkg::*;
#(
  parameter int N   = 12,
  parameter int SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam logic [SHW-1:0] LAST = SHW'(N - 1);

  logic [2*N-1:0] acc_p1;
  logic [N-1:0]   mcand_p1;
  logic [SHW-1:0] cnt_p1;
  logic           busy_p1;
  logic           done_p1;
  logic [N:0]     sum;

  // Multiplier sits in the low half and drains out of bit 0 as partial sums shift in.
  always_comb begin
    sum = {1'b0, acc_p1[2*N-1:N]} + {1'b0, (mcand_p1 & {N{acc_p1[0]}})};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p1   <= '0;
      mcand_p1 <= '0;
      cnt_p1   <= '0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      done_p1 <= 1'b0;
      if (start) begin
        mcand_p1 <= a;
        acc_p1   <= {{N{1'b0}}, b};
        cnt_p1   <= '0;
        busy_p1  <= 1'b1;
      end else if (busy_p1) begin
        acc_p1 <= {sum, acc_p1[N-1:1]};
        cnt_p1 <= cnt_p1 + 1'b1;
        if (cnt_p1 == LAST) begin
          busy_p1 <= 1'b0;
          done_p1 <= 1'b1;
        end
      end
    end
  end

  assign done = done_p1;
  assign prod = acc_p1;

endmodule

// File: rtl/seq_alu.sv
// Registered eight-op ALU with valid/ready on both sides and an iterative MUL.
// Optional signed overflow flag enabled by defining SEQ_ALU_SIGNED_OVF_EN.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N   = 12,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [2:0]   alu_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         cy,
  output logic         zero,
  output logic         ovf
);

  localparam logic [N-1:0] N_AMT = N'(N);

  state_t         state, state_nxt;
  op_t            op;
  logic           accept, load, mul_start, mul_done;
  logic [2*N-1:0] mul_prod;
  logic [N-1:0]   res;
  logic           res_cy, shamt_big;
  logic [N:0]     add_w, sub_w, shl_w, shr_w;

  assign op = op_t'(alu_op);

  seq_alu_mul #(.N(N), .SHW(SHW)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (in0),
    .b     (in1),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    mul_start = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        if (accept) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_nxt = ST_MULT;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_MULT: begin
        if (mul_done) begin
          load      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shifts use an N+1 bit window so the extra bit is the last bit shifted out.
  always_comb begin
    res       = '0;
    res_cy    = 1'b0;
    add_w     = {1'b0, in0} + {1'b0, in1};
    sub_w     = {1'b0, in0} - {1'b0, in1};
    shl_w     = {1'b0, in0} << in1;
    shr_w     = {in0, 1'b0} >> in1;
    shamt_big = (in1 >= N_AMT);
    if (state == ST_MULT) begin
      res    = mul_prod[N-1:0];
      res_cy = |mul_prod[2*N-1:N];
    end else begin
      case (op)
        OP_AND: res = in0 & in1;
        OP_ADD: {res_cy, res} = add_w;
        OP_SUB: {res_cy, res} = sub_w;
        OP_OR:  res = in0 | in1;
        OP_XOR: res = in0 ^ in1;
        OP_SHL: if (!shamt_big) {res_cy, res} = shl_w;
        OP_SHR: if (!shamt_big) {res, res_cy} = shr_w;
        default: begin
          res    = '0;
          res_cy = 1'b0;
        end
      endcase
    end
  end

  // Result stage: flags load only with a new result, otherwise held for the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      cy        <= 1'b0;
      zero      <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out       <= res;
      cy        <= res_cy;
      zero      <= (res == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SEQ_ALU_SIGNED_OVF_EN
  localparam logic signed [N-1:0] S_ZERO = '0;

  logic signed [N-1:0] a_s, b_s, r_s;
  logic                res_ovf;

  always_comb begin
    a_s     = $signed(in0);
    b_s     = $signed(in1);
    r_s     = $signed(res);
    res_ovf = 1'b0;
    if (state == ST_IDLE) begin
      case (op)
        OP_ADD: res_ovf = ((a_s < S_ZERO) == (b_s < S_ZERO)) && ((r_s < S_ZERO) != (a_s < S_ZERO));
        OP_SUB: res_ovf = ((a_s < S_ZERO) != (b_s < S_ZERO)) && ((r_s < S_ZERO) != (a_s < S_ZERO));
        default: res_ovf = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (load) ovf <= res_ovf;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed + short random bench for seq_alu with a result scoreboard.
module tb_seq_alu;

  localparam int N = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in0 = '0;
  logic [N-1:0] in1 = '0;
  logic [2:0]   alu_op = 3'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out;
  logic         cy, zero, ovf;

  always #5 clk = ~clk;

  seq_alu #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cy        (cy),
    .zero      (zero),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [N-1:0] r;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail = 0;
  bit   rand_bp = 1'b0;
  bit   last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t           e;
    logic [31:0]    s;
    logic [2*N-1:0] p;
    int             ub, sa, sb, sr;
    e  = '0;
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0: e.r = a & b;
      3'd1: begin
        s   = 32'(a) + 32'(b);
        e.r = s[N-1:0];
        e.c = s[N];
        sr  = sa + sb;
`ifdef SEQ_ALU_SIGNED_OVF_EN
        e.v = (sr > 2047) || (sr < -2048);
`endif
      end
      3'd2: begin
        e.r = a - b;
        e.c = (a < b);
        sr  = sa - sb;
`ifdef SEQ_ALU_SIGNED_OVF_EN
        e.v = (sr > 2047) || (sr < -2048);
`endif
      end
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: if (ub < N) begin
        e.r = a;
        for (int i = 0; i < ub; i++) begin
          e.c = e.r[N-1];
          e.r = {e.r[N-2:0], 1'b0};
        end
      end
      3'd6: if (ub < N) begin
        e.r = a;
        for (int i = 0; i < ub; i++) begin
          e.c = e.r[0];
          e.r = {1'b0, e.r[N-1:1]};
        end
      end
      default: begin
        p   = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        e.r = p[N-1:0];
        e.c = |p[2*N-1:N];
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // One clock: handshakes are sampled at the falling edge, outputs checked 1ns after the rise.
  task automatic tick();
    bit   do_pop, do_push;
    exp_t got, e, ex;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    do_pop  = rst_n && out_valid && out_ready;
    do_push = rst_n && in_valid && in_ready;
    got     = {out, cy, zero, ovf};
    e       = model(alu_op, in0, in1);
    @(posedge clk);
    #1;
    if (do_pop) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_result", 32'(got), 32'hFFFF_FFFF);
      end else begin
        ex = sbq.pop_front();
        chk("sb_result", 32'(got), 32'(ex));
      end
    end
    if (do_push) sbq.push_back(e);
    last_acc = do_push;
  endtask

  task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       output int cycles);
    alu_op   = op;
    in0      = a;
    in1      = b;
    in_valid = 1'b1;
    cycles   = 0;
    do begin
      tick();
      cycles++;
    end while (!last_acc && cycles < 100);
    in_valid = 1'b0;
    if (!last_acc) chk("issue_timeout", 32'(last_acc), 32'd1);
  endtask

  logic [2:0]   bop [8] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd6, 3'd1};
  logic [N-1:0] ba  [8] = '{12'hF0F, 12'h0A0, 12'hFF0, 12'h801, 12'h003, 12'h5A5, 12'hA80, 12'h7FF};
  logic [N-1:0] bb  [8] = '{12'h3C3, 12'h005, 12'h0FF, 12'h001, 12'h00C, 12'h000, 12'h005, 12'h001};

  initial begin
    int   cyc;
    exp_t held;

    // reset
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_flags", 32'({cy, zero, ovf}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD wrap to zero
    out_ready = 1'b1;
    issue(3'd1, 12'hFFF, 12'h001, cyc);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_out", 32'(out), 32'h000);
    chk("add_cy_zero", 32'({cy, zero}), 32'b11);
    tick();
    chk("add_valid_one_cycle", 32'(out_valid), 32'd0);

    // SUB with borrow
    issue(3'd2, 12'h005, 12'h007, cyc);
    chk("sub_out", 32'(out), 32'hFFE);
    chk("sub_cy_zero", 32'({cy, zero}), 32'b10);
`ifdef SEQ_ALU_SIGNED_OVF_EN
    issue(3'd2, 12'h800, 12'h001, cyc);
    chk("sub_ovf_out", 32'(out), 32'h7FF);
    chk("sub_ovf", 32'(ovf), 32'd1);
`endif

    // back-to-back single-cycle ops
    for (int i = 0; i < 8; i++) begin
      issue(bop[i], ba[i], bb[i], cyc);
      chk("b2b_rate", 32'(cyc), 32'd1);
      if (i == 3) chk("shl_out_cy", 32'({out, cy}), 32'({12'h002, 1'b1}));
      if (i == 4) chk("shr_big_out_cy_zero", 32'({out, cy, zero}), 32'({12'h000, 1'b0, 1'b1}));
    end
    tick();
    tick();

    // MUL latency and busy window
    issue(3'd7, 12'h040, 12'h040, cyc);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
      chk("mul_busy_out_valid", 32'(out_valid), 32'd0);
    end
    tick();
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_done_out_cy_zero", 32'({out, cy, zero}), 32'({12'h000, 1'b1, 1'b1}));
    tick();

    // MUL with operands changing after accept
    issue(3'd7, 12'h003, 12'h005, cyc);
    in0 = 12'hABC;
    in1 = 12'h123;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("mul2_valid", 32'(out_valid), 32'd1);
    chk("mul2_out_cy", 32'({out, cy}), 32'({12'h00F, 1'b0}));
    tick();

    // backpressure hold, then handshake with a pending request
    out_ready = 1'b0;
    issue(3'd1, 12'h123, 12'h456, cyc);
    held = {out, cy, zero, ovf};
    chk("bp_out", 32'(out), 32'h579);
    alu_op   = 3'd2;
    in0      = 12'h100;
    in1      = 12'h001;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_hold", 32'({out, cy, zero, ovf}), 32'(held));
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    chk("bp_new_valid", 32'(out_valid), 32'd1);
    chk("bp_new_out", 32'(out), 32'h0FF);
    tick();

    // reset in the middle of a MUL
    issue(3'd7, 12'h123, 12'h045, cyc);
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_out", 32'(out), 32'd0);
    chk("mrst_flags", 32'({cy, zero, ovf}), 32'd0);
    sbq.delete();
    rst_n = 1'b1;
    tick();
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("mrst_no_stale", 32'(out_valid), 32'd0);
    end

    // random ops with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [2:0]   op;
      logic [N-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = N'($urandom);
      b  = (op == 3'd5 || op == 3'd6) ? N'($urandom_range(0, 14)) : N'($urandom);
      issue(op, a, b, cyc);
    end
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && sbq.size() > 0; k++) tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
